// File: rtl/glitch_ctrl_pkg.sv
// Shared types for the glitch window controller: FSM states, latched config, helpers.
// GLITCH_WINDOW_REPEAT_EN adds the GAP state and the period/reps config fields.
package glitch_ctrl_pkg;

    localparam int unsigned GLITCH_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        COUNT = 3'd2,
        FIRE  = 3'd3,
`ifdef GLITCH_WINDOW_REPEAT_EN
        GAP   = 3'd4,
`endif
        DONE  = 3'd5
    } glitch_state_e;

    typedef struct packed {
        logic [GLITCH_CNT_W-1:0] offset;
        logic [GLITCH_CNT_W-1:0] width;
`ifdef GLITCH_WINDOW_REPEAT_EN
        logic [GLITCH_CNT_W-1:0] period;
        logic [7:0]              reps;
`endif
    } glitch_cfg_t;

    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef GLITCH_WINDOW_REPEAT_EN
    // Idle cycles between pulses; a period not longer than the width behaves as width + 1.
    function automatic logic [GLITCH_CNT_W-1:0] gap_len(input logic [GLITCH_CNT_W-1:0] period,
                                                        input logic [GLITCH_CNT_W-1:0] width);
        return (period > width) ? period - width : GLITCH_CNT_W'(1);
    endfunction
`endif

endpackage

// File: rtl/trig_edge_det.sv
// Registers the trigger bit and reports its registered level plus rise/fall edges.
module trig_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_i;
        end
    end

    assign level_o = trig_q;
    assign rise_o  = trig_i & ~trig_q;
    assign fall_o  = ~trig_i & trig_q;

endmodule

// File: rtl/glitch_window_ctrl.sv
// Cycle-accurate glitch scheduler: arms on config, counts from trigger rise, pulses glitch_o.
// Build with GLITCH_WINDOW_REPEAT_EN for periodic multi-pulse operation within one window.
module glitch_window_ctrl
    import glitch_ctrl_pkg::*;
#(
    parameter int unsigned GPIO_W     = 8,
    parameter int unsigned TRIGGERBIT = 0,
    parameter int unsigned CNT_W      = GLITCH_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [GPIO_W-1:0] gpio_out_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_offset_i,
    input  logic [CNT_W-1:0] cfg_width_i,
`ifdef GLITCH_WINDOW_REPEAT_EN
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [7:0]       cfg_reps_i,
`endif
    input  logic             abort_i,
    output logic             glitch_o,
    output logic             window_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             miss_o
);

    if (CNT_W != GLITCH_CNT_W) begin : g_cnt_w_check
        $error("glitch_window_ctrl: CNT_W must equal glitch_ctrl_pkg::GLITCH_CNT_W");
    end

    glitch_state_e    state_q;
    glitch_cfg_t      cfg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rem_q;
    logic             glitch_q;
    logic             done_q;
    logic             miss_q;
`ifdef GLITCH_WINDOW_REPEAT_EN
    logic [CNT_W-1:0] gap_q;
    logic [7:0]       reps_q;
`endif

    logic trig_level;
    logic rise;
    logic fall;

    trig_edge_det u_trig_edge_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .trig_i  (gpio_out_i[TRIGGERBIT]),
        .level_o (trig_level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            glitch_q <= 1'b0;
            done_q   <= 1'b0;
            miss_q   <= 1'b0;
`ifdef GLITCH_WINDOW_REPEAT_EN
            gap_q    <= '0;
            reps_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q  <= IDLE;
                glitch_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cfg_valid_i) begin
                            cfg_q.offset <= cfg_offset_i;
                            cfg_q.width  <= (cfg_width_i == '0) ? CNT_W'(1) : cfg_width_i;
`ifdef GLITCH_WINDOW_REPEAT_EN
                            cfg_q.period <= cfg_period_i;
                            cfg_q.reps   <= cfg_reps_i;
`endif
                            miss_q  <= 1'b0;
                            state_q <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (rise) begin
                            cnt_q <= '0;
                            rem_q <= cfg_q.width;
`ifdef GLITCH_WINDOW_REPEAT_EN
                            reps_q <= cfg_q.reps;
`endif
                            if (cfg_q.offset == '0) begin
                                glitch_q <= 1'b1;
                                state_q  <= FIRE;
                            end else begin
                                state_q  <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        cnt_q <= sat_inc(cnt_q);
                        if (fall) begin
                            miss_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (sat_inc(cnt_q) == cfg_q.offset) begin
                            glitch_q <= 1'b1;
                            rem_q    <= cfg_q.width;
                            state_q  <= FIRE;
                        end
                    end
                    FIRE: begin
                        cnt_q <= sat_inc(cnt_q);
                        if (rem_q == CNT_W'(1)) begin
                            // Trigger dropping on the final glitch cycle completes the pulse normally.
                            glitch_q <= 1'b0;
`ifdef GLITCH_WINDOW_REPEAT_EN
                            if (reps_q != '0) begin
                                if (fall) begin
                                    miss_q  <= 1'b1;
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                end else begin
                                    reps_q  <= reps_q - 1'b1;
                                    gap_q   <= gap_len(cfg_q.period, cfg_q.width);
                                    state_q <= GAP;
                                end
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
`else
                            done_q  <= 1'b1;
                            state_q <= DONE;
`endif
                        end else if (fall) begin
                            glitch_q <= 1'b0;
                            miss_q   <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rem_q <= rem_q - 1'b1;
                        end
                    end
`ifdef GLITCH_WINDOW_REPEAT_EN
                    GAP: begin
                        cnt_q <= sat_inc(cnt_q);
                        if (fall) begin
                            miss_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (gap_q == CNT_W'(1)) begin
                            glitch_q <= 1'b1;
                            rem_q    <= cfg_q.width;
                            state_q  <= FIRE;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
`endif
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        glitch_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign glitch_o    = glitch_q;
    assign done_o      = done_q;
    assign miss_o      = miss_q;
    assign cycle_o     = cnt_q;
    assign window_o    = trig_level;

endmodule

// File: tb/tb_glitch_window_ctrl.sv
// Directed bench for glitch_window_ctrl: per-cycle expectations are queued with each
// stimulus step and popped/compared at the falling clock edge.
module tb_glitch_window_ctrl;

    localparam int unsigned GPIO_W = 8;
    localparam int unsigned TRIG   = 0;
    localparam int unsigned CNT_W  = 16;

    logic             clk;
    logic             rst_n;
    logic [GPIO_W-1:0] gpio;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_offset;
    logic [CNT_W-1:0] cfg_width;
`ifdef GLITCH_WINDOW_REPEAT_EN
    logic [CNT_W-1:0] cfg_period;
    logic [7:0]       cfg_reps;
`endif
    logic             abort;
    logic             glitch;
    logic             window;
    logic [CNT_W-1:0] cycle;
    logic             busy;
    logic             done;
    logic             miss;

    glitch_window_ctrl #(
        .GPIO_W     (GPIO_W),
        .TRIGGERBIT (TRIG),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gpio_out_i   (gpio),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_offset_i (cfg_offset),
        .cfg_width_i  (cfg_width),
`ifdef GLITCH_WINDOW_REPEAT_EN
        .cfg_period_i (cfg_period),
        .cfg_reps_i   (cfg_reps),
`endif
        .abort_i      (abort),
        .glitch_o     (glitch),
        .window_o     (window),
        .cycle_o      (cycle),
        .busy_o       (busy),
        .done_o       (done),
        .miss_o       (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             g;
        logic             d;
        logic             m;
        logic             r;
        logic [CNT_W-1:0] c;
        bit               cc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic g, input logic d, input logic m, input logic r,
                        input int c, input bit cc);
        exp_t e;
        e.g = g; e.d = d; e.m = m; e.r = r; e.c = CNT_W'(c); e.cc = cc;
        sb.push_back(e);
    endtask

    task automatic configure(input string name, input int off, input int w,
                             input int period, input int reps);
        cfg_valid  = 1'b1;
        cfg_offset = CNT_W'(off);
        cfg_width  = CNT_W'(w);
`ifdef GLITCH_WINDOW_REPEAT_EN
        cfg_period = CNT_W'(period);
        cfg_reps   = 8'(reps);
`else
        if (period != 0 || reps != 0) $display("note: %s repeat fields ignored", name);
`endif
        tick();
        cfg_valid = 1'b0;
        check({name, ".cfg.busy"},  busy, 1);
        check({name, ".cfg.ready"}, cfg_ready, 0);
        check({name, ".cfg.miss"},  miss, 0);
    endtask

    // Runs n cycles popping one expectation per cycle; stimulus hooks keyed by cycle index.
    task automatic run_trace(input string name, input int n, input int fall_k,
                             input int abort_k, input int valid_k);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            tick();
            if (sb.size() == 0) begin
                check($sformatf("%s.k%0d.sb_empty", name, k), 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s.k%0d.glitch", name, k), glitch, e.g);
                check($sformatf("%s.k%0d.done",   name, k), done,   e.d);
                check($sformatf("%s.k%0d.miss",   name, k), miss,   e.m);
                check($sformatf("%s.k%0d.ready",  name, k), cfg_ready, e.r);
                check($sformatf("%s.k%0d.busy",   name, k), busy,   !e.r);
                if (e.cc) check($sformatf("%s.k%0d.cycle", name, k), cycle, e.c);
            end
            if (k == fall_k) gpio[TRIG] = 1'b0;
            abort = (k == abort_k);
            if (k == valid_k) begin
                cfg_valid  = 1'b1;
                cfg_offset = '0;
            end else begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic idle_low(input int n);
        gpio[TRIG] = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        gpio       = '0;
        cfg_valid  = 1'b0;
        cfg_offset = '0;
        cfg_width  = '0;
`ifdef GLITCH_WINDOW_REPEAT_EN
        cfg_period = '0;
        cfg_reps   = '0;
`endif
        abort      = 1'b0;

        #12;
        check("rst.ready",  cfg_ready, 1);
        check("rst.glitch", glitch, 0);
        check("rst.busy",   busy, 0);
        check("rst.done",   done, 0);
        check("rst.miss",   miss, 0);
        check("rst.window", window, 0);
        check("rst.cycle",  cycle, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // offset 5, width 3: glitch on cycles 5..7, done at 8
        configure("T1", 5, 3, 0, 0);
        for (int k = 0; k < 11; k++)
            push(k >= 5 && k <= 7, k == 8, 0, k >= 9, k, k <= 8);
        gpio[TRIG] = 1'b1;
        run_trace("T1", 11, -1, -1, -1);
        idle_low(2);

        // offset 0, width 0 (treated as 1): single glitch on cycle 0
        configure("T2", 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            push(k == 0, k == 1, 0, k >= 2, k, k <= 1);
        gpio[TRIG] = 1'b1;
        run_trace("T2", 4, -1, -1, -1);
        idle_low(2);

        // offset 10, width 4, trigger low from cycle 11: miss
        configure("T3", 10, 4, 0, 0);
        for (int k = 0; k < 15; k++)
            push(k == 10, k == 11, k >= 11, k >= 12, k, k <= 11);
        gpio[TRIG] = 1'b1;
        run_trace("T3", 15, 10, -1, -1);
        idle_low(2);
        check("T3.miss_sticky", miss, 1);

        // trigger already high when armed: only the second rise starts counting
        gpio[TRIG] = 1'b1;
        tick();
        configure("T4", 3, 1, 0, 0);
        check("T4.window", window, 1);
        for (int k = 0; k < 20; k++)
            push(0, 0, 0, 0, 0, 0);
        run_trace("T4hold", 20, -1, -1, -1);
        idle_low(2);
        for (int k = 0; k < 7; k++)
            push(k == 3, k == 4, 0, k >= 5, k, k <= 4);
        gpio[TRIG] = 1'b1;
        run_trace("T4", 7, -1, -1, -1);
        idle_low(2);

        // abort during FIRE at cycle 6; a config request mid-count is ignored
        configure("T5", 5, 8, 0, 0);
        for (int k = 0; k < 10; k++)
            push(k == 5 || k == 6, 0, 0, k >= 7, k, k <= 6);
        gpio[TRIG] = 1'b1;
        run_trace("T5", 10, -1, 6, 2);
        idle_low(2);

        // trigger drops on the last glitch cycle: completes without a miss
        configure("T6", 2, 3, 0, 0);
        for (int k = 0; k < 8; k++)
            push(k >= 2 && k <= 4, k == 5, 0, k >= 6, k, k <= 5);
        gpio[TRIG] = 1'b1;
        run_trace("T6", 8, 4, -1, -1);
        idle_low(2);

        // asynchronous reset while firing drops glitch_o without a clock edge
        configure("T7", 2, 5, 0, 0);
        for (int k = 0; k < 3; k++)
            push(k == 2, 0, 0, 0, k, 1);
        gpio[TRIG] = 1'b1;
        run_trace("T7", 3, -1, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("T7.rst.glitch", glitch, 0);
        check("T7.rst.ready",  cfg_ready, 1);
        check("T7.rst.busy",   busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_low(2);

`ifdef GLITCH_WINDOW_REPEAT_EN
        // offset 4, width 2, period 6, 3 pulses: 4-5, 10-11, 16-17, done at 18
        configure("T8", 4, 2, 6, 2);
        for (int k = 0; k < 21; k++)
            push((k >= 4 && k <= 5) || (k >= 10 && k <= 11) || (k >= 16 && k <= 17),
                 k == 18, 0, k >= 19, k, k <= 18);
        gpio[TRIG] = 1'b1;
        run_trace("T8", 21, -1, -1, -1);
        idle_low(2);
`endif

        check("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
